// File: rtl/wb_sched_if.sv
// wb_sched_if: bundles the execute, RAM and register-bank signals of the write-back scheduler.
//   alu_valid/alu_rd/alu_result/alu_ready : ALU result handshake
//   ld_req/ld_rd/ld_ready                 : load issue handshake
//   ram_valid/ram_data                    : RAM read return
//   wb_sel/wb_en/wb_addr/wb_data          : register bank write port
//   err                                   : sticky error flag
// master: environment side (execute, RAM, register bank); slave: the scheduler.
interface wb_sched_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_result;
    logic              alu_ready;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_rd;
    logic              ld_ready;
    logic              ram_valid;
    logic [DATA_W-1:0] ram_data;
    logic              wb_sel;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              err;

    modport master (
        output alu_valid, alu_rd, alu_result, ld_req, ld_rd, ram_valid, ram_data,
        input  alu_ready, ld_ready, wb_sel, wb_en, wb_addr, wb_data, err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_result, ld_req, ld_rd, ram_valid, ram_data,
        output alu_ready, ld_ready, wb_sel, wb_en, wb_addr, wb_data, err
    );
endinterface

// File: rtl/wb_sched.sv
// wb_sched: write-back scheduler for the register bank's single write port.
// Tracks one outstanding load, arbitrates the write port between RAM returns and ALU results
// (RAM first), stalls ALU writes that collide with the pending load's destination, and flags
// spurious RAM returns and load timeouts on a sticky err.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : wb_sched_if slave modport (ALU, load, RAM and write-port signals)
// All outputs are registered except alu_ready.
module wb_sched #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input logic        clk,
    input logic        rst,
    wb_sched_if.slave  bus
);
    localparam int unsigned TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic {StIdle, StLdWait} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pend_rd_q, pend_rd_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                err_q, err_d;
    logic                wb_en_q, wb_en_d;
    logic                wb_sel_q, wb_sel_d;
    logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                alu_ready;

    // RAM return owns the port; a WAW against the pending load waits for its write-back.
    assign alu_ready = !((state_q == StLdWait) && bus.ram_valid) &&
                       !((state_q == StLdWait) && (bus.alu_rd == pend_rd_q));

    always_comb begin
        state_d   = state_q;
        pend_rd_d = pend_rd_q;
        timer_d   = timer_q;
        err_d     = err_q;
        wb_en_d   = 1'b0;
        wb_sel_d  = wb_sel_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;

        // alu_ready is low whenever the RAM path writes, so the two never collide.
        if (bus.alu_valid && alu_ready) begin
            wb_en_d   = 1'b1;
            wb_sel_d  = 1'b0;
            wb_addr_d = bus.alu_rd;
            wb_data_d = bus.alu_result;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.ram_valid) begin
                    err_d = 1'b1;
                end
                if (bus.ld_req) begin
                    state_d   = StLdWait;
                    pend_rd_d = bus.ld_rd;
                    timer_d   = '0;
                end
            end
            StLdWait: begin
                if (bus.ram_valid) begin
                    state_d   = StIdle;
                    wb_en_d   = 1'b1;
                    wb_sel_d  = 1'b1;
                    wb_addr_d = pend_rd_q;
                    wb_data_d = bus.ram_data;
                end else if (timer_q == TIMER_LAST) begin
                    // Abort: drop the load, any later return counts as spurious.
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pend_rd_q <= '0;
            timer_q   <= '0;
            err_q     <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_sel_q  <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_rd_q <= pend_rd_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
            wb_en_q   <= wb_en_d;
            wb_sel_q  <= wb_sel_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign bus.alu_ready = alu_ready;
    assign bus.ld_ready  = (state_q == StIdle);
    assign bus.wb_en     = wb_en_q;
    assign bus.wb_sel    = wb_sel_q;
    assign bus.wb_addr   = wb_addr_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_wb_sched.sv
// tb_wb_sched: directed stimulus with a write-back scoreboard for wb_sched.
// Stimulus pushes each expected register write into a queue; a monitor pops and compares
// whenever wb_en is seen. Status outputs are checked directly from the stimulus process.
module tb_wb_sched;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;

    typedef struct packed {
        logic              sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   checks;
    int   passes;
    wr_t  exp_q[$];

    wb_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    wb_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic sel, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data);
        wr_t w;
        w.sel  = sel;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Monitor: sample on the falling edge, away from the active edge.
    initial begin
        wr_t w;
        wr_t got;
        forever begin
            @(negedge clk);
            if (!rst && bus.wb_en === 1'b1) begin
                got.sel  = bus.wb_sel;
                got.addr = bus.wb_addr;
                got.data = bus.wb_data;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write: got sel=%0d addr=%0d data=0x%08h, expected none",
                             got.sel, got.addr, got.data);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_sel", 32'(got.sel), 32'(w.sel));
                    check("wr_addr", 32'(got.addr), 32'(w.addr));
                    check("wr_data", got.data, w.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b1;
        bus.alu_valid  = 1'b0;
        bus.alu_rd     = '0;
        bus.alu_result = '0;
        bus.ld_req     = 1'b0;
        bus.ld_rd      = '0;
        bus.ram_valid  = 1'b0;
        bus.ram_data   = '0;
        #2;
        check("rst_wb_en", 32'(bus.wb_en), 0);
        check("rst_wb_sel", 32'(bus.wb_sel), 0);
        check("rst_wb_addr", 32'(bus.wb_addr), 0);
        check("rst_wb_data", bus.wb_data, 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_ld_ready", 32'(bus.ld_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // ALU write.
        tick();
        bus.alu_valid = 1'b1; bus.alu_rd = 4'd3; bus.alu_result = 32'h0000_00AA;
        #1 check("alu_ready_idle", 32'(bus.alu_ready), 1);
        expect_wr(1'b0, 4'd3, 32'h0000_00AA);
        tick();
        bus.alu_valid = 1'b0;
        tick();
        check("alu_wb_en_drop", 32'(bus.wb_en), 0);

        // Load with 3-cycle RAM latency.
        bus.ld_req = 1'b1; bus.ld_rd = 4'd5;
        tick();
        bus.ld_req = 1'b0;
        check("ld_ready_wait0", 32'(bus.ld_ready), 0);
        tick();
        check("ld_ready_wait1", 32'(bus.ld_ready), 0);
        tick();
        check("ld_ready_wait2", 32'(bus.ld_ready), 0);
        bus.ram_valid = 1'b1; bus.ram_data = 32'hDEAD_BEEF;
        expect_wr(1'b1, 4'd5, 32'hDEAD_BEEF);
        tick();
        bus.ram_valid = 1'b0;
        check("ld_ready_after", 32'(bus.ld_ready), 1);
        check("ld_wb_en", 32'(bus.wb_en), 1);

        // Port conflict: RAM first, ALU next cycle.
        tick();
        bus.ld_req = 1'b1; bus.ld_rd = 4'd5;
        tick();
        bus.ld_req = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 4'd2; bus.alu_result = 32'h11;
        bus.ram_valid = 1'b1; bus.ram_data = 32'h22;
        #1 check("conflict_alu_ready", 32'(bus.alu_ready), 0);
        expect_wr(1'b1, 4'd5, 32'h22);
        expect_wr(1'b0, 4'd2, 32'h11);
        tick();
        bus.ram_valid = 1'b0;
        #1 check("conflict_alu_ready_next", 32'(bus.alu_ready), 1);
        tick();
        bus.alu_valid = 1'b0;

        // WAW hazard on r7; independent r4 passes.
        tick();
        bus.ld_req = 1'b1; bus.ld_rd = 4'd7;
        tick();
        bus.ld_req = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 4'd7; bus.alu_result = 32'h77;
        #1 check("waw_stall0", 32'(bus.alu_ready), 0);
        tick();
        check("waw_stall1", 32'(bus.alu_ready), 0);
        bus.alu_rd = 4'd4; bus.alu_result = 32'h44;
        #1 check("waw_other_rd", 32'(bus.alu_ready), 1);
        expect_wr(1'b0, 4'd4, 32'h44);
        tick();
        bus.alu_rd = 4'd7; bus.alu_result = 32'h77;
        bus.ram_valid = 1'b1; bus.ram_data = 32'h70;
        #1 check("waw_stall_ram", 32'(bus.alu_ready), 0);
        expect_wr(1'b1, 4'd7, 32'h70);
        expect_wr(1'b0, 4'd7, 32'h77);
        tick();
        bus.ram_valid = 1'b0;
        #1 check("waw_release", 32'(bus.alu_ready), 1);
        tick();
        bus.alu_valid = 1'b0;
        tick();

        // Timeout: 16 cycles in LD_WAIT, then abort with err and no write.
        bus.ld_req = 1'b1; bus.ld_rd = 4'd9;
        tick();
        bus.ld_req = 1'b0;
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            check("to_wait_ld_ready", 32'(bus.ld_ready), 0);
            check("to_wait_err", 32'(bus.err), 0);
            tick();
        end
        check("to_ld_ready", 32'(bus.ld_ready), 1);
        check("to_err", 32'(bus.err), 1);
        check("to_wb_en", 32'(bus.wb_en), 0);

        // Spurious ram_valid in IDLE after reset.
        rst = 1'b1;
        #1 check("rst2_err", 32'(bus.err), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        bus.ram_valid = 1'b1; bus.ram_data = 32'h5A;
        tick();
        bus.ram_valid = 1'b0;
        check("spur_err", 32'(bus.err), 1);
        check("spur_wb_en", 32'(bus.wb_en), 0);

        // Async reset mid-load, with a fresh ALU write on the outputs.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        bus.ld_req = 1'b1; bus.ld_rd = 4'd6;
        tick();
        bus.ld_req = 1'b0;
        check("mid_ld_ready", 32'(bus.ld_ready), 0);
        bus.alu_valid = 1'b1; bus.alu_rd = 4'd2; bus.alu_result = 32'h55;
        expect_wr(1'b0, 4'd2, 32'h55);
        tick();
        bus.alu_valid = 1'b0;
        @(negedge clk);
        #2;
        check("mid_pre_wb_data", bus.wb_data, 32'h55);
        rst = 1'b1;
        #1;
        check("mid_rst_wb_en", 32'(bus.wb_en), 0);
        check("mid_rst_wb_addr", 32'(bus.wb_addr), 0);
        check("mid_rst_wb_data", bus.wb_data, 0);
        check("mid_rst_ld_ready", 32'(bus.ld_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        bus.ram_valid = 1'b1; bus.ram_data = 32'h99;
        tick();
        bus.ram_valid = 1'b0;
        check("mid_late_err", 32'(bus.err), 1);
        check("mid_late_wb_en", 32'(bus.wb_en), 0);

        tick();
        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
